gamepad_ctrl: RTL and testbench

GAMEPAD_CTRL -- requirements
Module: gamepad_ctrl

---
 rtl/gamepad_ctrl.sv | 133 +++++++++++++
 tb/tb_gamepad_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gamepad_ctrl.sv
// rtl/gamepad_ctrl.sv - two-pad serial gamepad poller (latch strobe + 12-bit shift read)
// Optional second-pad capture: define GAMEPAD_CTRL_P2_EN.
module gamepad_ctrl #(
    parameter int HALF_PERIOD  = 4,
    parameter int LATCH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic        pad_latch,
    output logic        pad_clk,
    input  logic [1:0]  pad_in,
    output logic [11:0] p1_btn,
    output logic [11:0] p2_btn
);
    typedef enum logic [1:0] {IDLE, LATCH, CLK_LO, CLK_HI} state_t;

    localparam logic [7:0] LATCH_LAST = 8'(LATCH_CYCLES - 1);
    localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        sample;
    logic        done;
    logic [11:0] cap1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sample  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LATCH;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d = CLK_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLK_LO: begin
                // data is taken only at the end of the low phase, after the pad has settled
                if (cnt_q == PHASE_LAST) begin
                    sample  = 1'b1;
                    state_d = CLK_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLK_HI: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 4'd11) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = CLK_LO;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            valid     <= 1'b0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            cap1_q    <= '0;
            p1_btn    <= '0;
        end else begin
            busy      <= (state_d != IDLE);
            valid     <= done;
            pad_latch <= (state_d == LATCH);
            pad_clk   <= (state_d == CLK_HI);
            if (sample)
                cap1_q <= {pad_in[0], cap1_q[11:1]};
            if (done)
                p1_btn <= cap1_q;
        end
    end

`ifdef GAMEPAD_CTRL_P2_EN
    logic [11:0] cap2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap2_q <= '0;
            p2_btn <= '0;
        end else begin
            if (sample)
                cap2_q <= {pad_in[1], cap2_q[11:1]};
            if (done)
                p2_btn <= cap2_q;
        end
    end
`else
    logic unused_pad_p2;
    assign unused_pad_p2 = pad_in[1];
    assign p2_btn        = 12'h000;
`endif

endmodule

// File: tb/tb_gamepad_ctrl.sv
// tb/tb_gamepad_ctrl.sv - randomized self-checking bench for gamepad_ctrl against a timing-rule model
module tb_gamepad_ctrl;
    localparam int HP   = 4;
    localparam int LC   = 8;
    localparam int POLL = LC + 24 * HP;
`ifdef GAMEPAD_CTRL_P2_EN
    localparam bit P2_ON = 1'b1;
`else
    localparam bit P2_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, start_b;
    logic [1:0]  pad_in, pad_in_b;
    logic        busy, valid, pad_latch, pad_clk;
    logic        busy_b, valid_b, pad_latch_b, pad_clk_b;
    logic [11:0] p1_btn, p2_btn, p1_btn_b, p2_btn_b;

    always #5 clk = ~clk;

    gamepad_ctrl #(.HALF_PERIOD(HP), .LATCH_CYCLES(LC)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .valid(valid),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .pad_in(pad_in),
        .p1_btn(p1_btn), .p2_btn(p2_btn)
    );

    gamepad_ctrl #(.HALF_PERIOD(2), .LATCH_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .valid(valid_b),
        .pad_latch(pad_latch_b), .pad_clk(pad_clk_b), .pad_in(pad_in_b),
        .p1_btn(p1_btn_b), .p2_btn(p2_btn_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pad shift-register models
    logic [11:0] word1 = '0, word2 = '0, sr1 = '0, sr2 = '0, prev_clk = '0;
    logic [11:0] word1_b = '0, word2_b = '0, sr1_b = '0, sr2_b = '0, prev_clk_b = '0;

    // reference model: poll accepted at edge t0 owns outputs from t0 to t0+POLL
    int          cyc = 0;
    int          t0 = 0;
    bit          active = 1'b0;
    logic [11:0] poll_w1 = '0, poll_w2 = '0, exp_p1 = '0, exp_p2 = '0;
    int          valid_cnt = 0;

    task automatic step();
        int o;
        logic e_busy, e_latch, e_clk, e_valid;
        @(posedge clk);
        cyc++;
        if (reset) begin
            active = 1'b0;
            exp_p1 = '0;
            exp_p2 = '0;
        end else if (start && (!active || cyc - 1 >= t0 + POLL)) begin
            active  = 1'b1;
            t0      = cyc;
            poll_w1 = word1;
            poll_w2 = word2;
        end
        @(negedge clk);
        if (pad_latch) begin
            sr1 = word1; sr2 = word2;
        end else if (pad_clk && !prev_clk[0]) begin
            sr1 = sr1 >> 1; sr2 = sr2 >> 1;
        end
        prev_clk[0] = pad_clk;
        pad_in = {sr2[0], sr1[0]};
        if (pad_latch_b) begin
            sr1_b = word1_b; sr2_b = word2_b;
        end else if (pad_clk_b && !prev_clk_b[0]) begin
            sr1_b = sr1_b >> 1; sr2_b = sr2_b >> 1;
        end
        prev_clk_b[0] = pad_clk_b;
        pad_in_b = {sr2_b[0], sr1_b[0]};

        o       = cyc - (t0 + LC);
        e_busy  = active && cyc >= t0 && cyc <= t0 + POLL - 1;
        e_latch = active && cyc >= t0 && cyc <= t0 + LC - 1;
        e_clk   = active && o >= 0 && o < 24 * HP && ((o / HP) % 2 == 1);
        e_valid = active && cyc == t0 + POLL;
        if (e_valid) begin
            exp_p1 = poll_w1;
            exp_p2 = P2_ON ? poll_w2 : 12'h000;
            valid_cnt++;
        end
        check($sformatf("busy@%0d", cyc), 32'(busy), 32'(e_busy));
        check($sformatf("valid@%0d", cyc), 32'(valid), 32'(e_valid));
        check($sformatf("pad_latch@%0d", cyc), 32'(pad_latch), 32'(e_latch));
        check($sformatf("pad_clk@%0d", cyc), 32'(pad_clk), 32'(e_clk));
        check($sformatf("p1_btn@%0d", cyc), 32'(p1_btn), 32'(exp_p1));
        check($sformatf("p2_btn@%0d", cyc), 32'(p2_btn), 32'(exp_p2));
    endtask

    task automatic drain();
        start = 1'b0;
        while (active && cyc < t0 + POLL) step();
    endtask

    task automatic one_poll(input logic [11:0] w1, input logic [11:0] w2);
        drain();
        word1 = w1; word2 = w2;
        start = 1'b1;
        step();
        start = 1'b0;
        drain();
        step();
    endtask

    initial begin
        int v0, nbusy, rst_at;
        bit got_valid, do_rst;
        reset = 1'b1; start = 1'b0; start_b = 1'b0;
        pad_in = '0; pad_in_b = '0;
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();

        one_poll(12'hA5C, 12'h3A7);
        one_poll(12'h001, 12'h800);

        // second start while busy is ignored
        drain();
        word1 = 12'h5A3; word2 = 12'h0F0;
        v0 = valid_cnt;
        start = 1'b1; step(); start = 1'b0;
        repeat (49) step();
        start = 1'b1; step(); start = 1'b0;
        drain(); step();
        check("ignored_start_valids", 32'(valid_cnt - v0), 32'd1);

        // start held high: back-to-back polls
        v0 = valid_cnt;
        start = 1'b1;
        repeat (3 * (POLL + 1)) step();
        start = 1'b0;
        drain(); step();
        check("held_start_valids", 32'(valid_cnt - v0), 32'd3);

        // completed FFF poll, then reset mid-way through a 000 poll
        one_poll(12'hFFF, 12'hFFF);
        word1 = 12'h000; word2 = 12'h000;
        v0 = valid_cnt;
        start = 1'b1; step(); start = 1'b0;
        repeat (59) step();
        reset = 1'b1; step(); reset = 1'b0;
        repeat (POLL) step();
        check("reset_abort_valids", 32'(valid_cnt - v0), 32'd0);

        // randomized polls with stray starts and occasional resets
        for (int it = 0; it < 20; it++) begin
            drain();
            word1  = 12'($urandom);
            word2  = 12'($urandom);
            do_rst = ($urandom_range(0, 5) == 0);
            rst_at = $urandom_range(0, POLL);
            repeat ($urandom_range(0, 4)) step();
            start = 1'b1; step();
            for (int k = 0; k <= POLL; k++) begin
                start = ($urandom_range(0, 15) == 0);
                reset = do_rst && (k == rst_at);
                if (reset) start = 1'b1;
                step();
            end
            start = 1'b0; reset = 1'b0;
        end
        drain(); step();

        // short-timing instance: HALF_PERIOD=2, LATCH_CYCLES=1
        word1_b = 12'h3C3; word2_b = 12'h4B1;
        start_b = 1'b1; step(); start_b = 1'b0;
        nbusy = 0; got_valid = 1'b0;
        for (int k = 0; k < 200 && !got_valid; k++) begin
            if (valid_b) got_valid = 1'b1;
            else begin
                if (busy_b) nbusy++;
                step();
            end
        end
        check("b_valid_seen", 32'(got_valid), 32'd1);
        check("b_busy_cycles", 32'(nbusy), 32'd49);
        check("b_p1_btn", 32'(p1_btn_b), 32'h3C3);
        check("b_p2_btn", 32'(p2_btn_b), P2_ON ? 32'h4B1 : 32'h000);
        check("b_busy_after", 32'(busy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
